// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the 8-entry FIFO control path.
package fifo_pkg;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  // Controller states. The encoding is fixed because the register file and
  // debug tooling decode these values directly.
  typedef enum logic [2:0] {
    INIT   = 3'd0,
    NO_OP  = 3'd1,
    WRITE  = 3'd2,
    WR_ERR = 3'd3,
    READ   = 3'd4,
    RD_ERR = 3'd5
  } state_t;

endpackage : fifo_pkg

// File: rtl/fifo_ctrl_ns.sv
// Combinational next-state, next-pointer and next-count logic for fifo_ctrl.
// The request decode is the same from every state, so the current state is
// not an input here.
module fifo_ctrl_ns
  import fifo_pkg::*;
(
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              full,
  input  logic              empty,
  input  logic [ADDR_W-1:0] head,
  input  logic [ADDR_W-1:0] tail,
  input  logic [CNT_W-1:0]  count,
  output state_t            state_next,
  output logic [ADDR_W-1:0] head_next,
  output logic [ADDR_W-1:0] tail_next,
  output logic [CNT_W-1:0]  count_next,
  output logic              we,
  output logic              re
);

  // Decode the request pair against occupancy and derive the strobes.
  always_comb begin
    // NOTE: every output gets a value before any branch so no path through
    // this block leaves one unassigned (which would infer a latch).
    state_next = NO_OP;
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    we         = 1'b0;
    re         = 1'b0;

    unique case ({wr_en, rd_en})
      2'b10: begin
        if (!full) begin
          state_next = WRITE;
          we         = reset_n;
          tail_next  = tail + ADDR_W'(1);  // wraps modulo DEPTH
          count_next = count + CNT_W'(1);
        end else begin
          state_next = WR_ERR;
        end
      end
      2'b01: begin
        if (!empty) begin
          state_next = READ;
          re         = reset_n;
          head_next  = head + ADDR_W'(1);  // wraps modulo DEPTH
          count_next = count - CNT_W'(1);
        end else begin
          state_next = RD_ERR;
        end
      end
      // Idle, or simultaneous read and write: nothing moves, no ack/error.
      default: state_next = NO_OP;
    endcase
  end

endmodule : fifo_ctrl_ns

// File: rtl/fifo_ctrl.sv
// Control path of the 8-entry FIFO: state/pointer/count registers with a
// synchronous reset, plus occupancy and handshake decode.
module fifo_ctrl
  import fifo_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              re,
  output logic [ADDR_W-1:0] raddr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);

  state_t            state_q, state_next;
  logic [ADDR_W-1:0] head_q, head_next;
  logic [ADDR_W-1:0] tail_q, tail_next;
  logic [CNT_W-1:0]  count_q, count_next;

  // Occupancy flags come from the registered count only.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  fifo_ctrl_ns u_ns (
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .full       (full),
    .empty      (empty),
    .head       (head_q),
    .tail       (tail_q),
    .count      (count_q),
    .state_next (state_next),
    .head_next  (head_next),
    .tail_next  (tail_next),
    .count_next (count_next),
    .we         (we),
    .re         (re)
  );

  // State, pointer and count registers; reset overrides any request.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled only on the clock edge, so it is tested inside
    // the block rather than listed in the sensitivity list; non-blocking
    // assignments keep every register updating from pre-edge values.
    if (!reset_n) begin
      state_q <= INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_next;
      head_q  <= head_next;
      tail_q  <= tail_next;
      count_q <= count_next;
    end
  end

  assign waddr = tail_q;
  assign raddr = head_q;
  assign count = count_q;

  // Moore handshake flags: they report the outcome of last cycle's request.
  assign wr_ack = (state_q == WRITE);
  assign wr_err = (state_q == WR_ERR);
  assign rd_ack = (state_q == READ);
  assign rd_err = (state_q == RD_ERR);

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against an
// occupancy/outcome model.
module tb_fifo_ctrl;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic       we;
  logic [2:0] waddr;
  logic       re;
  logic [2:0] raddr;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       wr_ack;
  logic       wr_err;
  logic       rd_ack;
  logic       rd_err;

  int n_total = 0;
  int n_pass  = 0;

  fifo_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .we      (we),
    .waddr   (waddr),
    .re      (re),
    .raddr   (raddr),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .wr_ack  (wr_ack),
    .wr_err  (wr_err),
    .rd_ack  (rd_ack),
    .rd_err  (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: number of entries held, where the next write and read
  // land, and what happened to the last clocked request
  // (0 nothing, 1 write accepted, 2 write refused, 3 read accepted, 4 read refused).
  int m_count = 0;
  int m_head  = 0;
  int m_tail  = 0;
  int m_last  = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_count = 0; m_head = 0; m_tail = 0; m_last = 0; m_valid = 1;
    end else if (wr_en && !rd_en) begin
      if (m_count < 8) begin
        m_tail = (m_tail + 1) % 8; m_count = m_count + 1; m_last = 1;
      end else m_last = 2;
    end else if (rd_en && !wr_en) begin
      if (m_count > 0) begin
        m_head = (m_head + 1) % 8; m_count = m_count - 1; m_last = 3;
      end else m_last = 4;
    end else begin
      m_last = 0;
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("we",     32'(we),     32'(reset_n && wr_en && !rd_en && m_count < 8));
      check("re",     32'(re),     32'(reset_n && rd_en && !wr_en && m_count > 0));
      check("waddr",  32'(waddr),  32'(m_tail));
      check("raddr",  32'(raddr),  32'(m_head));
      check("count",  32'(count),  32'(m_count));
      check("full",   32'(full),   32'(m_count == 8));
      check("empty",  32'(empty),  32'(m_count == 0));
      check("wr_ack", 32'(wr_ack), 32'(m_last == 1));
      check("wr_err", 32'(wr_err), 32'(m_last == 2));
      check("rd_ack", 32'(rd_ack), 32'(m_last == 3));
      check("rd_err", 32'(rd_err), 32'(m_last == 4));
    end
  end

  // Apply one cycle's inputs just after the rising edge.
  task automatic drive(input logic w, input logic r, input logic rn);
    @(posedge clk);
    #1;
    wr_en = w; rd_en = r; reset_n = rn;
  endtask

  // Settle point for literal checks, clear of the model's compare instant.
  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

    // Reset for two edges.
    drive(0, 0, 0);
    drive(0, 0, 1);
    peek();
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full), 0);
    check("rst_flags", 32'({wr_ack, wr_err, rd_ack, rd_err, we, re}), 0);
    check("rst_ptrs",  32'({waddr, raddr}), 0);

    // Fill.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1);
      peek();
      check("fill_we", 32'(we), 1);
      check("fill_waddr", 32'(waddr), 32'(i));
      if (i > 0) check("fill_ack", 32'(wr_ack), 1);
    end
    drive(0, 0, 1);
    peek();
    check("fill_last_ack", 32'(wr_ack), 1);
    check("fill_count", 32'(count), 8);
    check("fill_full", 32'(full), 1);
    check("fill_tail_wrap", 32'(waddr), 0);

    // Overflow.
    drive(1, 0, 1);
    peek();
    check("ovf_we", 32'(we), 0);
    drive(0, 0, 1);
    peek();
    check("ovf_err", 32'(wr_err), 1);
    check("ovf_count", 32'(count), 8);
    check("ovf_tail", 32'(waddr), 0);
    drive(0, 0, 1);
    peek();
    check("ovf_err_once", 32'(wr_err), 0);

    // Drain and underflow.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1);
      peek();
      check("drain_re", 32'(re), 1);
      check("drain_raddr", 32'(raddr), 32'(i));
      if (i > 0) check("drain_ack", 32'(rd_ack), 1);
    end
    drive(0, 1, 1);
    peek();
    check("udf_re", 32'(re), 0);
    check("udf_last_ack", 32'(rd_ack), 1);
    check("udf_count", 32'(count), 0);
    check("udf_empty", 32'(empty), 1);
    drive(0, 0, 1);
    peek();
    check("udf_err", 32'(rd_err), 1);
    check("udf_head", 32'(raddr), 0);

    // Simultaneous request with three entries held.
    repeat (3) drive(1, 0, 1);
    drive(1, 1, 1);
    peek();
    check("sim_we", 32'(we), 0);
    check("sim_re", 32'(re), 0);
    check("sim_count", 32'(count), 3);
    drive(0, 0, 1);
    peek();
    check("sim_flags", 32'({wr_ack, wr_err, rd_ack, rd_err}), 0);
    check("sim_count_after", 32'(count), 3);

    // Reach count=5, head=2, tail=7, then reset during a write.
    repeat (2) drive(0, 1, 1);
    repeat (4) drive(1, 0, 1);
    drive(1, 0, 0);
    peek();
    check("mid_we", 32'(we), 0);
    check("mid_count_pre", 32'(count), 5);
    check("mid_head_pre", 32'(raddr), 2);
    check("mid_tail_pre", 32'(waddr), 7);
    drive(0, 0, 1);
    peek();
    check("mid_count", 32'(count), 0);
    check("mid_ptrs", 32'({waddr, raddr}), 0);
    check("mid_flags", 32'({wr_ack, wr_err, rd_ack, rd_err}), 0);

    // Randomized traffic with shifting write/read bias and rare resets.
    for (int blk = 0; blk < 40; blk++) begin
      int wp;
      int rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int c = 0; c < 50; c++) begin
        drive(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
              ($urandom_range(0, 99) != 0));
      end
    end
    drive(0, 0, 1);
    peek();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_fifo_ctrl
